// File: rtl/ce_prescaler.sv
// ce_prescaler: programmable down-counting clock-enable generator with periodic and one-shot modes.
// start arms a period of div_reg cycles; ce_out strobes for one cycle when the counter expires.
module ce_prescaler #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             div_ld,
    input  logic [WIDTH-1:0] div_in,
    output logic             ce_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_reg;
    logic             mode_reg;
    assign count = cnt;
    // div_reg updates by non-blocking assignment, so a same-edge start or reload still sees the old divisor
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div_reg  <= WIDTH'(DEFAULT_DIV);
            mode_reg <= 1'b0;
            ce_out   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (div_ld && div_in != '0) div_reg <= div_in;
            ce_out <= 1'b0;
            if (stop) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                state    <= RUN;
                cnt      <= div_reg - WIDTH'(1);
                mode_reg <= mode;
                busy     <= 1'b1;
                done     <= 1'b0;
            end else if (state == RUN && en) begin
                if (cnt != '0) begin
                    cnt <= cnt - WIDTH'(1);
                end else begin
                    ce_out <= 1'b1;
                    if (mode_reg) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= div_reg - WIDTH'(1);
                    end
                end
            end
        end
    end
endmodule
